// File: rtl/debug_cmd_decoder.sv
// Debug command decoder.
// Turns the byte stream from the debug UART receiver into CPU run control,
// a breakpoint register, an instruction-memory write stream and OK-response
// requests for the UART transmitter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for an opcode byte
//   S_BP    | collecting the 4-byte little-endian breakpoint after RESUME
//   S_PLEN  | collecting the 2-byte little-endian word count after PROGRAM
//   S_PDATA | collecting 4-byte little-endian instruction words

module debug_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PADDR_WIDTH    = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   cpu_pause,
    output logic                   step_pulse,
    output logic                   bp_en,
    output logic [31:0]            bp_addr,
    output logic                   prog_active,
    output logic                   prog_we,
    output logic [PADDR_WIDTH-1:0] prog_addr,
    output logic [31:0]            prog_data,
    output logic                   prog_done,
    output logic                   err_pulse
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]      OP_OK    = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BP,
        S_PLEN,
        S_PDATA
    } state_t;

    state_t                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [31:0]            asm_q;
    logic [15:0]            words_left_q;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   ok_pending_q, ok_pending_d;
    logic                   done_pend_q;
    logic                   cpu_pause_q, step_pulse_q, bp_en_q;
    logic [31:0]            bp_addr_q;
    logic                   prog_active_q, prog_we_q, prog_done_q, err_q;
    logic [PADDR_WIDTH-1:0] prog_addr_q;
    logic [31:0]            prog_data_q;

    logic [31:0] asm_word;
    logic [15:0] len_word;
    logic        ping;
    logic        tmo_fire;

    // Incoming bytes shift in from the top, so after four bytes the first
    // received byte sits in bits [7:0] (little-endian assembly).
    assign asm_word = {rx_data, asm_q[31:8]};
    assign len_word = {rx_data, asm_q[31:24]};

    // OK-request bookkeeping and the inter-byte timeout down-counter.
    always_comb begin
        ping         = rx_valid && (state_q == S_IDLE) && (rx_data == 8'h03);
        ok_pending_d = (ok_pending_q && !tx_ready) || ping;
        tmo_fire     = !rx_valid && (state_q != S_IDLE) && (tmo_q == TW'(1));
        tmo_d        = tmo_q;
        if (rx_valid || (state_q == S_IDLE)) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TW'(1);
        end
    end

    // Protocol FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            words_left_q  <= '0;
            tmo_q         <= TMO_LOAD;
            ok_pending_q  <= 1'b0;
            done_pend_q   <= 1'b0;
            cpu_pause_q   <= 1'b1;
            step_pulse_q  <= 1'b0;
            bp_en_q       <= 1'b0;
            bp_addr_q     <= '0;
            prog_active_q <= 1'b0;
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_data_q   <= '0;
            prog_done_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            ok_pending_q <= ok_pending_d;
            tmo_q        <= tmo_d;
            step_pulse_q <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_done_q  <= 1'b0;
            err_q        <= 1'b0;

            // Address advances the cycle after each write, wrapping naturally.
            if (prog_we_q) begin
                prog_addr_q <= prog_addr_q + PADDR_WIDTH'(1);
            end

            // Completion is reported one cycle after the final write.
            if (done_pend_q) begin
                prog_done_q   <= 1'b1;
                prog_active_q <= 1'b0;
                done_pend_q   <= 1'b0;
            end

            if (tmo_fire) begin
                // Abort the frame; partial data is dropped, cpu_pause untouched.
                err_q         <= 1'b1;
                state_q       <= S_IDLE;
                prog_active_q <= 1'b0;
                byte_cnt_q    <= '0;
            end else if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        byte_cnt_q <= '0;
                        case (rx_data)
                            8'h03: ;
                            8'h04: cpu_pause_q <= 1'b1;
                            8'h05: state_q <= S_BP;
                            8'h06: if (cpu_pause_q) step_pulse_q <= 1'b1;
                            8'h07: begin
                                state_q       <= S_PLEN;
                                prog_active_q <= 1'b1;
                                cpu_pause_q   <= 1'b1;
                            end
                            8'hFF: ;
                            default: err_q <= 1'b1;
                        endcase
                    end
                    S_BP: begin
                        asm_q      <= asm_word;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            bp_addr_q   <= asm_word;
                            bp_en_q     <= (asm_word != 32'hFFFF_FFFF);
                            cpu_pause_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    S_PLEN: begin
                        asm_q <= asm_word;
                        if (byte_cnt_q == 2'd1) begin
                            words_left_q <= len_word;
                            prog_addr_q  <= '0;
                            byte_cnt_q   <= '0;
                            if (len_word == 16'd0) begin
                                prog_done_q   <= 1'b1;
                                prog_active_q <= 1'b0;
                                state_q       <= S_IDLE;
                            end else begin
                                state_q <= S_PDATA;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                    S_PDATA: begin
                        asm_q      <= asm_word;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            prog_we_q    <= 1'b1;
                            prog_data_q  <= asm_word;
                            words_left_q <= words_left_q - 16'd1;
                            if (words_left_q == 16'd1) begin
                                state_q     <= S_IDLE;
                                done_pend_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_valid    = ok_pending_q;
    assign tx_data     = OP_OK;
    assign cpu_pause   = cpu_pause_q;
    assign step_pulse  = step_pulse_q;
    assign bp_en       = bp_en_q;
    assign bp_addr     = bp_addr_q;
    assign prog_active = prog_active_q;
    assign prog_we     = prog_we_q;
    assign prog_addr   = prog_addr_q;
    assign prog_data   = prog_data_q;
    assign prog_done   = prog_done_q;
    assign err_pulse   = err_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Bench for debug_cmd_decoder: directed byte frames, expected TX bytes and
// instruction writes queued by the stimulus and popped by a negedge monitor.

module tb_debug_cmd_decoder;

    localparam int TMO = 100;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          cpu_pause;
    logic          step_pulse;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic          prog_active;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          prog_done;
    logic          err_pulse;

    debug_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .PADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .cpu_pause(cpu_pause), .step_pulse(step_pulse), .bp_en(bp_en),
        .bp_addr(bp_addr), .prog_active(prog_active), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_done(prog_done),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } we_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = -10;
    int step_seen = 0;
    int err_seen = 0;
    int done_seen = 0;
    logic [7:0] exp_tx[$];
    we_t        exp_we[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        logic [7:0] et;
        we_t        ew;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %02h, none expected", tx_data);
                end else begin
                    et = exp_tx.pop_front();
                    if (tx_data !== et) begin
                        errors++;
                        $display("FAIL tx_data: got %02h, expected %02h", tx_data, et);
                    end
                end
            end
            if (prog_we) begin
                checks++;
                last_we_cyc = cyc;
                if (exp_we.size() == 0) begin
                    errors++;
                    $display("FAIL we_unexpected: got addr %0h data %08h", prog_addr, prog_data);
                end else begin
                    ew = exp_we.pop_front();
                    if (prog_addr !== ew.a || prog_data !== ew.d) begin
                        errors++;
                        $display("FAIL prog_write: got %0h/%08h, expected %0h/%08h",
                                 prog_addr, prog_data, ew.a, ew.d);
                    end
                end
            end
            if (prog_done) begin
                done_seen++;
                checks++;
                if (cyc != last_we_cyc + 1) begin
                    errors++;
                    $display("FAIL done_timing: done at cycle %0d, last write at %0d", cyc, last_we_cyc);
                end
            end
            if (step_pulse) step_seen++;
            if (err_pulse)  err_seen++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_valid"},    32'(tx_valid),    32'd0);
        chk({tag, "_cpu_pause"},   32'(cpu_pause),   32'd1);
        chk({tag, "_bp_en"},       32'(bp_en),       32'd0);
        chk({tag, "_bp_addr"},     bp_addr,          32'd0);
        chk({tag, "_prog_active"}, 32'(prog_active), 32'd0);
        chk({tag, "_prog_addr"},   32'(prog_addr),   32'd0);
        chk({tag, "_prog_data"},   prog_data,        32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int err_exp;
        int step_exp;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        err_exp = 0; step_exp = 0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_reset_vals("reset");

        // PING with ready transmitter
        exp_tx.push_back(8'h02);
        send(8'h03);
        tick(3);
        chk("ping_ok_drained", 32'(exp_tx.size()), 32'd0);
        chk("ping_no_err", 32'(err_seen), 32'(err_exp));

        // RESUME with breakpoint 0x18, NEXT ignored while running
        send_seq('{8'h05, 8'h18, 8'h00, 8'h00, 8'h00});
        chk("bp_addr_18", bp_addr, 32'h0000_0018);
        chk("bp_en_on", 32'(bp_en), 32'd1);
        chk("run_pause0", 32'(cpu_pause), 32'd0);
        send(8'h06);
        chk("next_while_running", 32'(step_seen), 32'(step_exp));
        send(8'h04);
        chk("pause_cmd", 32'(cpu_pause), 32'd1);
        step_exp++;
        send(8'h06);
        tick(2);
        chk("next_step", 32'(step_seen), 32'(step_exp));

        // Opcode values inside a payload are data
        send_seq('{8'h05, 8'h04, 8'h06, 8'h00, 8'h00});
        chk("bp_payload_data", bp_addr, 32'h0000_0604);
        chk("bp_payload_nostep", 32'(step_seen), 32'(step_exp));
        chk("bp_payload_pause", 32'(cpu_pause), 32'd0);

        // All-ones breakpoint means free run
        send_seq('{8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        chk("bp_free_en", 32'(bp_en), 32'd0);
        chk("bp_free_pause", 32'(cpu_pause), 32'd0);

        // PROGRAM two words
        exp_we.push_back('{a: AW'(0), d: 32'h0000_0001});
        exp_we.push_back('{a: AW'(1), d: 32'hDEAD_BEEF});
        send_seq('{8'h07, 8'h02, 8'h00, 8'h01, 8'h00});
        chk("prog_active_mid", 32'(prog_active), 32'd1);
        chk("prog_pause_mid", 32'(cpu_pause), 32'd1);
        send_seq('{8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        tick(2);
        chk("prog_writes_done", 32'(exp_we.size()), 32'd0);
        chk("prog_done_count", 32'(done_seen), 32'd1);
        chk("prog_active_end", 32'(prog_active), 32'd0);
        chk("prog_pause_end", 32'(cpu_pause), 32'd1);
        chk("prog_addr_end", 32'(prog_addr), 32'd2);

        // Timeout mid-word
        send_seq('{8'h07, 8'h01, 8'h00, 8'h11, 8'h22});
        tick(TMO - 12);
        chk("tmo_not_early", 32'(err_seen), 32'(err_exp));
        err_exp++;
        tick(20);
        chk("tmo_err", 32'(err_seen), 32'(err_exp));
        chk("tmo_active", 32'(prog_active), 32'd0);
        chk("tmo_pause", 32'(cpu_pause), 32'd1);
        exp_tx.push_back(8'h02);
        send(8'h03);
        tick(3);
        chk("tmo_idle_ping", 32'(exp_tx.size()), 32'd0);

        // Unknown byte vs. ignored FF
        err_exp++;
        send(8'h55);
        send(8'hFF);
        tick(2);
        chk("bad_op_err", 32'(err_seen), 32'(err_exp));
        chk("bad_op_pause", 32'(cpu_pause), 32'd1);
        chk("bad_op_bp", bp_addr, 32'hFFFF_FFFF);
        chk("bad_op_active", 32'(prog_active), 32'd0);

        // Coalesced PINGs while transmitter is busy
        tx_ready = 1'b0;
        exp_tx.push_back(8'h02);
        send(8'h03);
        tick(4);
        send(8'h03);
        tick(6);
        chk("ok_waiting", 32'(tx_valid), 32'd1);
        chk("ok_held", 32'(exp_tx.size()), 32'd1);
        tx_ready = 1'b1;
        tick(4);
        chk("ok_coalesced", 32'(exp_tx.size()), 32'd0);

        // PING arriving on the handshake cycle yields a second OK
        tx_ready = 1'b0;
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h02);
        send(8'h03);
        tick(2);
        rx_valid = 1'b1; rx_data = 8'h03; tx_ready = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(4);
        chk("ok_ping_on_hs", 32'(exp_tx.size()), 32'd0);
        chk("ok_idle_after", 32'(tx_valid), 32'd0);

        // Reset in the middle of PDATA
        exp_we.push_back('{a: AW'(0), d: 32'hDDCC_BBAA});
        send_seq('{8'h05, 8'h40, 8'h00, 8'h00, 8'h00});
        send_seq('{8'h07, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});
        chk("pre_rst_active", 32'(prog_active), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_vals("midrst");
        tick(TMO + 10);
        chk("midrst_no_err", 32'(err_seen), 32'(err_exp));
        exp_tx.push_back(8'h02);
        send(8'h03);
        tick(3);

        chk("final_tx_empty", 32'(exp_tx.size()), 32'd0);
        chk("final_we_empty", 32'(exp_we.size()), 32'd0);
        chk("final_steps", 32'(step_seen), 32'(step_exp));
        chk("final_done", 32'(done_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
